alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered WIDTH-bit ALU with {V,N,C,Z} flags and valid/ready
//               handshakes. Define ALU_MUL_EN to build the iterative
//               shift-add multiplier on opcode 0 (otherwise opcode 0 is a NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       opcode_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] ans_out,
  output logic [3:0]       flags_out
);

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, BUSY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept;

  logic [WIDTH-1:0] alu_ans;
  logic             alu_v, alu_c;
  logic [WIDTH:0]   add_full, sub_full, inc_full, dec_full;

  assign ready_out = (state_q == IDLE) | ((state_q == DONE) & ready_in);
  assign accept    = valid_in & ready_out;
  assign valid_out = (state_q == DONE);
  assign ans_out   = ans_q;
  assign flags_out = flags_q;

  // Single-cycle datapath; the top bit of each extended sum is carry or borrow.
  always_comb begin
    add_full = {1'b0, a_in} + {1'b0, b_in};
    sub_full = {1'b0, a_in} - {1'b0, b_in};
    inc_full = {1'b0, a_in} + {{WIDTH{1'b0}}, 1'b1};
    dec_full = {1'b0, a_in} - {{WIDTH{1'b0}}, 1'b1};
    alu_ans  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (opcode_in)
      4'h1: alu_ans = a_in;
      4'h2: begin
        alu_ans = inc_full[WIDTH-1:0];
        alu_c   = inc_full[WIDTH];
        alu_v   = ~a_in[WIDTH-1] & alu_ans[WIDTH-1];
      end
      4'h3: begin
        alu_ans = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) & (alu_ans[WIDTH-1] != a_in[WIDTH-1]);
      end
      4'h4: begin
        alu_ans = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) & (alu_ans[WIDTH-1] != a_in[WIDTH-1]);
      end
      4'h5: begin
        alu_ans = dec_full[WIDTH-1:0];
        alu_c   = dec_full[WIDTH];
        alu_v   = a_in[WIDTH-1] & ~alu_ans[WIDTH-1];
      end
      4'h6: alu_ans = ~a_in;
      4'h7: alu_ans = a_in & b_in;
      4'h8: alu_ans = ~(a_in & b_in);
      4'h9: alu_ans = a_in | b_in;
      4'hA: alu_ans = ~(a_in | b_in);
      4'hB: alu_ans = a_in ^ b_in;
      4'hC: alu_ans = a_in ~^ b_in;
      4'hD: alu_ans = (a_in > b_in) ? a_in : b_in;
      4'hE: alu_ans = (a_in < b_in) ? a_in : b_in;
      4'hF: begin
        alu_c   = (a_in == b_in);
        alu_ans = alu_c ? a_in : '0;
      end
      default: alu_ans = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     part_sum;

  // prod holds {partial high, remaining multiplier bits}; shifts right each step.
  always_comb begin
    part_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});
    prod_step = {part_sum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    if ((state_q == DONE) && ready_in) state_d = IDLE;
`ifdef ALU_MUL_EN
    if (state_q == BUSY) begin
      prod_d = prod_step;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = DONE;
        ans_d   = prod_step[WIDTH-1:0];
        flags_d = {1'b0, prod_step[WIDTH-1], |prod_step[2*WIDTH-1:WIDTH],
                   ~|prod_step[WIDTH-1:0]};
      end
    end
`endif
    if (accept) begin
`ifdef ALU_MUL_EN
      if (opcode_in == 4'h0) begin
        state_d = BUSY;
        mcand_d = a_in;
        prod_d  = {{WIDTH{1'b0}}, b_in};
        cnt_d   = CNT_W'(WIDTH);
      end else
`endif
      begin
        state_d = DONE;
        ans_d   = alu_ans;
        flags_d = {alu_v, alu_ans[WIDTH-1], alu_c, ~|alu_ans};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ans_q   <= '0;
      flags_q <= '0;
`ifdef ALU_MUL_EN
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ans_q   <= ans_d;
      flags_q <= flags_d;
`ifdef ALU_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed scoreboard bench for alu_seq (WIDTH = 8), both
//               ALU_MUL_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   opcode_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] ans_out;
  logic [3:0]   flags_out;

  alu_seq #(.WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .a_in      (a_in),
    .b_in      (b_in),
    .opcode_in (opcode_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .ans_out   (ans_out),
    .flags_out (flags_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [W-1:0] ans;
    logic [3:0]   flags;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, ans_out);
    end else begin
      e = sb.pop_front();
      check({tag, " ans"}, 32'(ans_out), 32'(e.ans));
      check({tag, " flags"}, 32'(flags_out), 32'(e.flags));
    end
  endtask

  // Starts one cycle-phase after a rising edge with the DUT idle; leaves it idle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ea,
                       input logic [3:0] ef, input int lat);
    int n;
    opcode_in = op;
    a_in      = a;
    b_in      = b;
    valid_in  = 1'b1;
    ready_in  = 1'b1;
    sb.push_back('{ans: ea, flags: ef});
    #1;
    check({tag, " ready"}, 32'(ready_out), 32'd1);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    a_in     = ~a;
    b_in     = ~b;
    n = 0;
    while (valid_out !== 1'b1 && n < W + 4) begin
      check({tag, " busy ready"}, 32'(ready_out), 32'd0);
      @(posedge clk_in); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat - 1));
    check({tag, " valid"}, 32'(valid_out), 32'd1);
    pop_check(tag);
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in  = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b1;
    a_in      = '0;
    b_in      = '0;
    opcode_in = '0;
    #2;
    check("rst valid", 32'(valid_out), 32'd0);
    check("rst ans", 32'(ans_out), 32'd0);
    check("rst flags", 32'(flags_out), 32'd0);
    check("rst ready", 32'(ready_out), 32'd1);
    #10 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    do_op("add_ff_01", 4'h3, 8'hFF, 8'h01, 8'h00, 4'b0011, 1);
    do_op("sub_80_01", 4'h4, 8'h80, 8'h01, 8'h7F, 4'b1000, 1);
    do_op("dec_00",    4'h5, 8'h00, 8'h00, 8'hFF, 4'b0110, 1);
`ifdef ALU_MUL_EN
    do_op("mul_15_17", 4'h0, 8'd15, 8'd17, 8'hFF, 4'b0100, MUL_LAT);
    do_op("mul_16_16", 4'h0, 8'd16, 8'd16, 8'h00, 4'b0011, MUL_LAT);
`else
    do_op("nop_15_17", 4'h0, 8'd15, 8'd17, 8'h00, 4'b0001, MUL_LAT);
    do_op("nop_16_16", 4'h0, 8'd16, 8'd16, 8'h00, 4'b0001, MUL_LAT);
`endif
    do_op("inc_7f",    4'h2, 8'h7F, 8'h00, 8'h80, 4'b1100, 1);
    do_op("inc_ff",    4'h2, 8'hFF, 8'h00, 8'h00, 4'b0011, 1);
    do_op("add_7f_01", 4'h3, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    do_op("pass",      4'h1, 8'hC3, 8'hA5, 8'hC3, 4'b0100, 1);
    do_op("not",       4'h6, 8'hC3, 8'hA5, 8'h3C, 4'b0000, 1);
    do_op("and",       4'h7, 8'hC3, 8'hA5, 8'h81, 4'b0100, 1);
    do_op("nand",      4'h8, 8'hC3, 8'hA5, 8'h7E, 4'b0000, 1);
    do_op("or",        4'h9, 8'hC3, 8'hA5, 8'hE7, 4'b0100, 1);
    do_op("nor",       4'hA, 8'hC3, 8'hA5, 8'h18, 4'b0000, 1);
    do_op("xor",       4'hB, 8'hC3, 8'hA5, 8'h66, 4'b0000, 1);
    do_op("xnor",      4'hC, 8'hC3, 8'hA5, 8'h99, 4'b0100, 1);

    // Backpressure: result must hold while the consumer stalls, then hand over.
    opcode_in = 4'h3; a_in = 8'h10; b_in = 8'h20; valid_in = 1'b1; ready_in = 1'b0;
    sb.push_back('{ans: 8'h30, flags: 4'b0000});
    @(posedge clk_in); #1;
    opcode_in = 4'hB; a_in = 8'hF0; b_in = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 32'(valid_out), 32'd1);
      check("bp ans", 32'(ans_out), 32'h30);
      check("bp flags", 32'(flags_out), 32'd0);
      check("bp ready", 32'(ready_out), 32'd0);
      @(posedge clk_in); #1;
    end
    pop_check("bp add");
    ready_in = 1'b1;
    sb.push_back('{ans: 8'hFF, flags: 4'b0100});
    #1;
    check("bp ready_comb", 32'(ready_out), 32'd1);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    check("bp xor valid", 32'(valid_out), 32'd1);
    pop_check("bp xor");
    @(posedge clk_in); #1;
    check("bp idle", 32'(valid_out), 32'd0);

    do_op("max", 4'hD, 8'h80, 8'h7F, 8'h80, 4'b0100, 1);
    do_op("min", 4'hE, 8'h80, 8'h7F, 8'h7F, 4'b0000, 1);
    do_op("eq_5_5", 4'hF, 8'h05, 8'h05, 8'h05, 4'b0010, 1);
    do_op("eq_5_6", 4'hF, 8'h05, 8'h06, 8'h00, 4'b0001, 1);
    do_op("nz_prev", 4'h1, 8'h5A, 8'h00, 8'h5A, 4'b0000, 1);

    // Abort an in-flight operation with an asynchronous reset.
`ifdef ALU_MUL_EN
    opcode_in = 4'h0; a_in = 8'd3; b_in = 8'd3; valid_in = 1'b1; ready_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
`else
    opcode_in = 4'h3; a_in = 8'd1; b_in = 8'd1; valid_in = 1'b1; ready_in = 1'b0;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
`endif
    #1 rst_n_in = 1'b0;
    #1;
    check("abort valid", 32'(valid_out), 32'd0);
    check("abort ans", 32'(ans_out), 32'd0);
    check("abort flags", 32'(flags_out), 32'd0);
    check("abort ready", 32'(ready_out), 32'd1);
    #1 rst_n_in = 1'b1;
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    check("post abort valid", 32'(valid_out), 32'd0);
    do_op("add_3_4", 4'h3, 8'd3, 8'd4, 8'h07, 4'b0000, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
